mem_port_arbiter: RTL

//  Shares one single-port memory between the fetch port (rom_addr side) and the MEM-stage data

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arb_wdog.sv | 37 +++
 rtl/mem_port_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      D_BUSY = 2'd1,
      I_BUSY = 2'd2
   } arb_state_e;

   typedef enum logic {
      FETCH = 1'b0,
      DATA  = 1'b1
   } grant_e;

   localparam logic [2:0] RW_BYTE  = 3'b000;
   localparam logic [2:0] RW_HALF  = 3'b001;
   localparam logic [2:0] RW_WORD  = 3'b010;
   localparam logic [2:0] RW_BYTEU = 3'b100;
   localparam logic [2:0] RW_HALFU = 3'b101;

   localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
   localparam logic [2:0]  FETCH_TYPE = RW_WORD;

endpackage

// File: rtl/mem_arb_wdog.sv
// Watchdog for the arbiter: counts stalled memory cycles, raises hit on the
// TO_CYC-th consecutive wait cycle of an access.
module mem_arb_wdog #(
   parameter int unsigned TO_CYC = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic hit
);

   localparam logic [15:0] LAST = 16'(TO_CYC - 1);

   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != LAST)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   // Current cycle counts as a wait cycle, so the hit fires when the stored count is one short.
   assign hit = en && (cnt_q == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and MEM-stage data.
// Optional statistics counters enabled by defining MEM_ARB_STAT_EN.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned TO_CYC = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_done,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [2:0]        d_type,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_done,
   output logic              mem_req,
   output logic              mem_we,
   output logic [2:0]        mem_type,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              stall,
   output logic              err_timeout,
   output logic [31:0]       stat_conflict,
   output logic [31:0]       stat_wait
);

   arb_state_e        state_q, state_d;
   grant_e            last_q, last_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [2:0]        mem_type_q, mem_type_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              if_done_q, if_done_d;
   logic              d_done_q, d_done_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              err_q, err_d;

   logic i_pend, d_pend;
   logic wd_clr, wd_en, wd_hit;

   assign i_pend = if_req & ~if_done_q;
   assign d_pend = d_req & ~d_done_q;
   assign wd_en  = mem_req_q & ~mem_ack;

   mem_arb_wdog #(
      .TO_CYC(TO_CYC)
   ) u_wdog (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (wd_clr),
      .en   (wd_en),
      .hit  (wd_hit)
   );

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_type_d  = mem_type_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_done_d   = 1'b0;
      d_done_d    = 1'b0;
      if_rdata_d  = '0;
      d_rdata_d   = '0;
      err_d       = err_q;
      wd_clr      = 1'b0;

      case (state_q)
         IDLE: begin
            if (d_pend && ((last_q == FETCH) || !i_pend)) begin
               state_d     = D_BUSY;
               last_d      = DATA;
               mem_req_d   = 1'b1;
               mem_we_d    = d_we;
               mem_type_d  = d_type;
               mem_addr_d  = d_addr;
               mem_wdata_d = d_wdata;
               wd_clr      = 1'b1;
            end else if (i_pend) begin
               state_d     = I_BUSY;
               last_d      = FETCH;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_type_d  = FETCH_TYPE;
               mem_addr_d  = if_addr;
               mem_wdata_d = '0;
               wd_clr      = 1'b1;
            end
         end

         D_BUSY, I_BUSY: begin
            // A real ack wins over a simultaneous watchdog expiry.
            if (mem_ack || wd_hit) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               if (!mem_ack) begin
                  err_d = 1'b1;
               end
               if (state_q == D_BUSY) begin
                  d_done_d  = 1'b1;
                  d_rdata_d = (mem_ack && !mem_we_q) ? mem_rdata : '0;
               end else begin
                  if_done_d  = 1'b1;
                  if_rdata_d = mem_ack ? mem_rdata : DATA_W'(NOP_INSTR);
               end
            end
         end

         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         last_q      <= FETCH;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_type_q  <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_done_q   <= 1'b0;
         d_done_q    <= 1'b0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_type_q  <= mem_type_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_done_q   <= if_done_d;
         d_done_q    <= d_done_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
         err_q       <= err_d;
      end
   end

   assign mem_req     = mem_req_q;
   assign mem_we      = mem_we_q;
   assign mem_type    = mem_type_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign if_done     = if_done_q;
   assign d_done      = d_done_q;
   assign if_rdata    = if_rdata_q;
   assign d_rdata     = d_rdata_q;
   assign err_timeout = err_q;
   assign stall       = i_pend | d_pend;

`ifdef MEM_ARB_STAT_EN
   logic [31:0] stat_conflict_q, stat_conflict_d;
   logic [31:0] stat_wait_q, stat_wait_d;

   always_comb begin
      stat_conflict_d = stat_conflict_q;
      stat_wait_d     = stat_wait_q;
      if (i_pend && d_pend && (stat_conflict_q != '1)) begin
         stat_conflict_d = stat_conflict_q + 32'd1;
      end
      if (wd_en && (stat_wait_q != '1)) begin
         stat_wait_d = stat_wait_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_conflict_q <= '0;
         stat_wait_q     <= '0;
      end else begin
         stat_conflict_q <= stat_conflict_d;
         stat_wait_q     <= stat_wait_d;
      end
   end

   assign stat_conflict = stat_conflict_q;
   assign stat_wait     = stat_wait_q;
`else
   assign stat_conflict = '0;
   assign stat_wait     = '0;
`endif

endmodule
